pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline controller for the 4-register MIPS pipeline (pipe1=ID, pipe2=EX, pipe3=MEM, pipe4=WB). It generates every `pipeN_allow_in` and gated `pipeN_valid_out` consumed by the Reg_N_N+1 stage registers. It detects load-use hazards, sequences the multi-cycle divider in EX, selects forwarding sources, and flushes/redirects the pipe when WB commits an exception or eret.

## Interface
Parameters:
- DIV_CYCLES, 33, cycles a divide occupies EX including the start cycle; legal range ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid / id_rs / id_rt / id_rs_use / id_rt_use  in  1/5/5/1/1  ID instruction and its source use flags
- ex_valid / ex_dest / ex_reg_we / ex_load_op / ex_div_op  in  1/5/1/1/1  EX instruction info
- mem_valid / mem_dest / mem_reg_we / mem_ready  in  1/5/1/1  MEM info; mem_ready=0 means data access pending
- wb_valid / wb_dest / wb_reg_we / wb_exc / wb_eret  in  1/5/1/1/1  WB info and commit events
- pipe1_allow_in, pipe2_allow_in, pipe3_allow_in, pipe4_allow_in  out  1 each  stage may accept new content
- pipe1_valid_out, pipe2_valid_out, pipe3_valid_out  out  1 each  gated valid into the next stage register
- flush  out  1  kill all instructions younger than WB, including IF
- redirect_valid / redirect_sel  out  1/1  PC redirect; sel 0=exception vector, 1=EPC
- div_start / div_busy  out  1/1  divider launch pulse; divider occupied
- fwd_rs_sel / fwd_rt_sel  out  2/2  0=regfile, 1=EX, 2=MEM, 3=WB

## Operation
- Readiness terms:
  - id_ready = !load_use.
  - load_use = ex_valid & ex_load_op & ex_reg_we & ex_dest≠0 & ((id_rs_use & id_rs==ex_dest) | (id_rt_use & id_rt==ex_dest)).
  - ex_ready = !ex_div_op | (cnt==1).
  - mem_ready comes from the input.
- Allow chain:
  - pipe4_allow_in = 1.
  - pipe3_allow_in = !mem_valid | mem_ready.
  - pipe2_allow_in = !ex_valid | (ex_ready & pipe3_allow_in).
  - pipe1_allow_in = !id_valid | (id_ready & pipe2_allow_in).
- Valid gating: pipe1_valid_out = id_valid & id_ready & !flush; pipe2_valid_out = ex_valid & ex_ready & !flush; pipe3_valid_out = mem_valid & mem_ready & !flush. A load-use stall therefore inserts a bubble into EX.
- Flush: flush = wb_valid & (wb_exc | wb_eret), combinational. While flush=1, all allow_in = 1 and all valid_out = 0, so bubbles load everywhere.
- Divider counter `cnt`, idle at 0:
  - When ex_valid & ex_div_op & cnt==0 & !flush: div_start=1, cnt←DIV_CYCLES-1.
  - When cnt>1: cnt decrements.
  - When cnt==1: cnt←0 only if pipe3_allow_in; otherwise it holds at 1, so a finished divide waits for MEM without relaunching.
  - Flush forces cnt←0 and suppresses div_start.
  - div_busy = (cnt≠0) | div_start.
- Forwarding, per source register, priority EX > MEM > WB:
  - A stage matches when its valid & reg_we & dest≠0 & dest==source.
  - An EX match with ex_load_op set never selects 1; load_use covers that case.
  - No match selects 0.

## Timing
- Reset values: cnt=0, redirect_valid=0, redirect_sel=0, div_start=0, div_busy=0. With all valid inputs low, every allow_in is 1 and every valid_out is 0.
- redirect_valid is registered: flush in cycle t gives redirect_valid=1 in t+1 for exactly one cycle, with redirect_sel = wb_eret captured at t.
- wb_exc and wb_eret both high: treat as exception, so redirect_sel=0.
- Divide latency: the divide occupies EX for exactly DIV_CYCLES cycles when MEM is ready, i.e. pipe2_valid_out is high in the last of those cycles.
- Load-use costs exactly one bubble cycle.
- Flush and div_start in the same cycle: flush wins.
- Reset during a divide or a pending redirect clears both on the next edge.
- A second flush cannot occur in t+1, because the pipe is empty after a flush.

## Structure
- Shared package `pipe_pkg` holds:
  - the fwd_sel encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB);
  - the redirect_sel encodings (REDIR_EXC, REDIR_EPC);
  - the stage-index constants.
- One natural sub-module: `div_seq`, which holds cnt, div_start and div_busy.
- Hazard, forwarding, allow chain and flush logic stay in the top module.

## Test plan
- Load-use: ex_valid=1, ex_load_op=1, ex_dest=5; id_rs=5, id_rs_use=1 → pipe1_allow_in=0 and pipe1_valid_out=0 for 1 cycle; next cycle the load is in MEM and fwd_rs_sel=2.
- Forward priority: EX, MEM and WB all write r7; ID reads r7 as rt → fwd_rt_sel=1; with EX writing r0 instead → fwd_rt_sel=2.
- Divide: DIV_CYCLES=4, div in EX → div_start pulses once, pipe2_allow_in=0 for 3 cycles, and pipe2_valid_out=1 on the 4th. With mem_ready=0 at that point: cnt holds at 1 and there is no second div_start.
- Exception mid-divide: wb_exc=1 while cnt=2 → flush=1, all valid_out=0, all allow_in=1, cnt=0 next cycle, redirect_valid=1 with redirect_sel=0 in the following cycle.
- eret: wb_eret=1 → redirect_sel=1. With wb_exc=1 and wb_eret=1 together → redirect_sel=0.
- Reset asserted mid-divide with cnt=10 → cnt=0, div_busy=0, redirect_valid=0 after one edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the 4-register MIPS pipeline controller.
// Forwarding-source and redirect-target codes live here so stage logic agrees.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   localparam logic REDIR_EXC = 1'b0;
   localparam logic REDIR_EPC = 1'b1;

   localparam int STAGE_ID  = 1;
   localparam int STAGE_EX  = 2;
   localparam int STAGE_MEM = 3;
   localparam int STAGE_WB  = 4;

   function automatic logic stage_match(input logic       valid,
                                        input logic       reg_we,
                                        input logic [4:0] dest,
                                        input logic [4:0] src);
      stage_match = valid & reg_we & (dest != 5'd0) & (dest == src);
   endfunction

   // A load in EX cannot supply data yet, so its match is ignored here.
   function automatic logic [1:0] fwd_pick(input logic ex_hit,
                                           input logic ex_load,
                                           input logic mem_hit,
                                           input logic wb_hit);
      if (ex_hit & ~ex_load) begin
         fwd_pick = FWD_EX;
      end else if (mem_hit) begin
         fwd_pick = FWD_MEM;
      end else if (wb_hit) begin
         fwd_pick = FWD_WB;
      end else begin
         fwd_pick = FWD_RF;
      end
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Divider occupancy sequencer: launches a divide held in EX and counts it down.
// A finished divide parks at count 1 until MEM can accept it.
module div_seq #(
   parameter int DIV_CYCLES = 33
) (
   input  logic clk,
   input  logic reset,
   input  logic ex_valid,
   input  logic ex_div_op,
   input  logic flush,
   input  logic pipe3_allow_in,
   output logic div_start,
   output logic div_busy,
   output logic div_last
);
   import pipe_pkg::*;

   localparam int               CNT_W    = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             start_s;

   // launch decode: only from idle, never on a flush cycle
   always_comb begin
      start_s = ex_valid & ex_div_op & (cnt_r == CNT_ZERO) & ~flush;
   end

   // countdown with hold-at-one while MEM is stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= CNT_ZERO;
      end else if (flush) begin
         cnt_r <= CNT_ZERO;
      end else if (start_s) begin
         cnt_r <= CNT_LOAD;
      end else if (cnt_r > CNT_ONE) begin
         cnt_r <= cnt_r - CNT_ONE;
      end else if ((cnt_r == CNT_ONE) && pipe3_allow_in) begin
         cnt_r <= CNT_ZERO;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign div_start = start_s;
   assign div_busy  = (cnt_r != CNT_ZERO) | start_s;
   assign div_last  = (cnt_r == CNT_ONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: allow chain, valid gating, load-use stall,
// forwarding select, WB-commit flush/redirect and divider sequencing.
module pipe_hazard_ctrl #(
   parameter int DIV_CYCLES = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_use,
   input  logic       id_rt_use,
   input  logic       ex_valid,
   input  logic [4:0] ex_dest,
   input  logic       ex_reg_we,
   input  logic       ex_load_op,
   input  logic       ex_div_op,
   input  logic       mem_valid,
   input  logic [4:0] mem_dest,
   input  logic       mem_reg_we,
   input  logic       mem_ready,
   input  logic       wb_valid,
   input  logic [4:0] wb_dest,
   input  logic       wb_reg_we,
   input  logic       wb_exc,
   input  logic       wb_eret,
   output logic       pipe1_allow_in,
   output logic       pipe2_allow_in,
   output logic       pipe3_allow_in,
   output logic       pipe4_allow_in,
   output logic       pipe1_valid_out,
   output logic       pipe2_valid_out,
   output logic       pipe3_valid_out,
   output logic       flush,
   output logic       redirect_valid,
   output logic       redirect_sel,
   output logic       div_start,
   output logic       div_busy,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel
);
   import pipe_pkg::*;

   logic flush_s;
   logic load_use_s;
   logic ex_ready_s;
   logic raw3_s;
   logic raw2_s;
   logic raw1_s;
   logic div_last_s;
   logic redir_valid_r;
   logic redir_sel_r;

   // hazard terms and allow chain; a flush opens every stage to bubbles
   always_comb begin
      flush_s    = wb_valid & (wb_exc | wb_eret);
      load_use_s = ex_valid & ex_load_op & ex_reg_we & (ex_dest != 5'd0) &
                   ((id_rs_use & (id_rs == ex_dest)) | (id_rt_use & (id_rt == ex_dest)));
      ex_ready_s = ~ex_div_op | div_last_s;
      raw3_s     = ~mem_valid | mem_ready;
      raw2_s     = ~ex_valid | (ex_ready_s & raw3_s);
      raw1_s     = ~id_valid | (~load_use_s & raw2_s);
   end

   assign flush           = flush_s;
   assign pipe4_allow_in  = 1'b1;
   assign pipe3_allow_in  = raw3_s | flush_s;
   assign pipe2_allow_in  = raw2_s | flush_s;
   assign pipe1_allow_in  = raw1_s | flush_s;
   assign pipe1_valid_out = id_valid & ~load_use_s & ~flush_s;
   assign pipe2_valid_out = ex_valid & ex_ready_s & ~flush_s;
   assign pipe3_valid_out = mem_valid & mem_ready & ~flush_s;

   // forwarding select, EX over MEM over WB
   always_comb begin
      fwd_rs_sel = fwd_pick(stage_match(ex_valid, ex_reg_we, ex_dest, id_rs), ex_load_op,
                            stage_match(mem_valid, mem_reg_we, mem_dest, id_rs),
                            stage_match(wb_valid, wb_reg_we, wb_dest, id_rs));
      fwd_rt_sel = fwd_pick(stage_match(ex_valid, ex_reg_we, ex_dest, id_rt), ex_load_op,
                            stage_match(mem_valid, mem_reg_we, mem_dest, id_rt),
                            stage_match(wb_valid, wb_reg_we, wb_dest, id_rt));
   end

   // one-cycle redirect after a flush; exception wins over eret
   always_ff @(posedge clk) begin
      if (reset) begin
         redir_valid_r <= 1'b0;
         redir_sel_r   <= REDIR_EXC;
      end else if (flush_s) begin
         redir_valid_r <= 1'b1;
         redir_sel_r   <= (wb_eret & ~wb_exc) ? REDIR_EPC : REDIR_EXC;
      end else begin
         redir_valid_r <= 1'b0;
         redir_sel_r   <= redir_sel_r;
      end
   end

   assign redirect_valid = redir_valid_r;
   assign redirect_sel   = redir_sel_r;

   div_seq #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_seq (
      .clk            (clk),
      .reset          (reset),
      .ex_valid       (ex_valid),
      .ex_div_op      (ex_div_op),
      .flush          (flush_s),
      .pipe3_allow_in (pipe3_allow_in),
      .div_start      (div_start),
      .div_busy       (div_busy),
      .div_last       (div_last_s)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a timestamp-based reference model
// predicts each cycle's outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_rs_use, id_rt_use;
   logic [4:0] id_rs, id_rt;
   logic ex_valid, ex_reg_we, ex_load_op, ex_div_op;
   logic [4:0] ex_dest;
   logic mem_valid, mem_reg_we, mem_ready;
   logic [4:0] mem_dest;
   logic wb_valid, wb_reg_we, wb_exc, wb_eret;
   logic [4:0] wb_dest;
   logic pipe1_allow_in, pipe2_allow_in, pipe3_allow_in, pipe4_allow_in;
   logic pipe1_valid_out, pipe2_valid_out, pipe3_valid_out;
   logic flush, redirect_valid, redirect_sel, div_start, div_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
      .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_reg_we(ex_reg_we), .ex_load_op(ex_load_op), .ex_div_op(ex_div_op),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_reg_we(mem_reg_we), .mem_ready(mem_ready),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_reg_we(wb_reg_we), .wb_exc(wb_exc), .wb_eret(wb_eret),
      .pipe1_allow_in(pipe1_allow_in), .pipe2_allow_in(pipe2_allow_in),
      .pipe3_allow_in(pipe3_allow_in), .pipe4_allow_in(pipe4_allow_in),
      .pipe1_valid_out(pipe1_valid_out), .pipe2_valid_out(pipe2_valid_out), .pipe3_valid_out(pipe3_valid_out),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
      .div_start(div_start), .div_busy(div_busy), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
   );

   typedef struct {
      logic [3:0] allow;   // {p4,p3,p2,p1}
      logic [2:0] vout;    // {p3,p2,p1}
      logic       flush, rv, rsel, dstart, dbusy;
      logic [1:0] frs, frt;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference state: divide tracked by launch timestamp, not a countdown
   bit m_div_on   = 1'b0;
   int m_launch   = 0;
   int cyc        = 0;
   bit m_rv       = 1'b0;
   bit m_rsel     = 1'b0;

   function automatic bit m_div_done();
      return m_div_on && ((cyc - m_launch) >= DC - 1);
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      logic [1:0] r;
      r = 2'd0;
      // scan oldest to youngest so the youngest producer wins
      if (wb_valid && wb_reg_we && wb_dest != 5'd0 && wb_dest == src) r = 2'd3;
      if (mem_valid && mem_reg_we && mem_dest != 5'd0 && mem_dest == src) r = 2'd2;
      if (ex_valid && ex_reg_we && !ex_load_op && ex_dest != 5'd0 && ex_dest == src) r = 2'd1;
      return r;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit fl, lu, exr, a3, a2, a1;
      fl  = wb_valid && (wb_exc || wb_eret);
      lu  = ex_valid && ex_load_op && ex_reg_we && ex_dest != 5'd0 &&
            ((id_rs_use && id_rs == ex_dest) || (id_rt_use && id_rt == ex_dest));
      exr = !ex_div_op || m_div_done();
      a3  = !mem_valid || mem_ready;
      a2  = !ex_valid || (exr && a3);
      a1  = !id_valid || (!lu && a2);
      e.allow  = fl ? 4'hF : {1'b1, a3, a2, a1};
      e.vout   = fl ? 3'b000 : {mem_valid && mem_ready, ex_valid && exr, id_valid && !lu};
      e.flush  = fl;
      e.rv     = m_rv;
      e.rsel   = m_rsel;
      e.dstart = !m_div_on && ex_valid && ex_div_op && !fl;
      e.dbusy  = m_div_on || e.dstart;
      e.frs    = ref_fwd(id_rs);
      e.frt    = ref_fwd(id_rt);
      return e;
   endfunction

   task automatic model_update();
      bit fl, a3;
      fl = wb_valid && (wb_exc || wb_eret);
      a3 = !mem_valid || mem_ready;
      if (reset) begin
         m_div_on = 1'b0; m_rv = 1'b0; m_rsel = 1'b0;
      end else begin
         m_rv = fl;
         if (fl) m_rsel = wb_eret && !wb_exc;
         if (fl) m_div_on = 1'b0;
         else if (!m_div_on && ex_valid && ex_div_op) begin
            m_div_on = 1'b1; m_launch = cyc;
         end else if (m_div_done() && a3) m_div_on = 1'b0;
      end
      cyc++;
   endtask

   task automatic clear_in();
      reset = 1'b0;
      id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_use = 1'b0; id_rt_use = 1'b0;
      ex_valid = 1'b0; ex_dest = 5'd0; ex_reg_we = 1'b0; ex_load_op = 1'b0; ex_div_op = 1'b0;
      mem_valid = 1'b0; mem_dest = 5'd0; mem_reg_we = 1'b0; mem_ready = 1'b1;
      wb_valid = 1'b0; wb_dest = 5'd0; wb_reg_we = 1'b0; wb_exc = 1'b0; wb_eret = 1'b0;
   endtask

   // inputs for this cycle are already applied: predict, then advance one edge
   task automatic step();
      sbq.push_back(model_out());
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_div(input int n);
      ex_valid = 1'b1; ex_div_op = 1'b1; ex_reg_we = 1'b1; ex_dest = 5'd3;
      repeat (n) step();
   endtask

   task automatic gen_random();
      bit prev_fl;
      prev_fl = m_rv;
      reset     = ($urandom_range(0, 149) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      id_rs_use = 1'($urandom_range(0, 1));
      id_rt_use = 1'($urandom_range(0, 1));
      ex_dest   = 5'($urandom_range(0, 3));
      ex_reg_we = 1'($urandom_range(0, 1));
      if (m_div_on && $urandom_range(0, 9) != 0) begin
         ex_valid = 1'b1; ex_div_op = 1'b1; ex_load_op = 1'b0;
      end else begin
         ex_valid   = ($urandom_range(0, 3) != 0);
         ex_div_op  = ($urandom_range(0, 4) == 0);
         ex_load_op = ($urandom_range(0, 2) == 0);
      end
      mem_valid  = ($urandom_range(0, 3) != 0);
      mem_dest   = 5'($urandom_range(0, 3));
      mem_reg_we = 1'($urandom_range(0, 1));
      mem_ready  = ($urandom_range(0, 3) != 0);
      wb_valid   = ($urandom_range(0, 3) != 0);
      wb_dest    = 5'($urandom_range(0, 3));
      wb_reg_we  = 1'($urandom_range(0, 1));
      wb_exc     = !prev_fl && ($urandom_range(0, 29) == 0);
      wb_eret    = !prev_fl && ($urandom_range(0, 29) == 0);
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0h, required %0h", nm, $time, act, req);
      end
   endtask

   // monitor: outputs are presented every cycle, compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("allow_in", {pipe4_allow_in, pipe3_allow_in, pipe2_allow_in, pipe1_allow_in}, e.allow);
            chk("valid_out", {1'b0, pipe3_valid_out, pipe2_valid_out, pipe1_valid_out}, {1'b0, e.vout});
            chk("flush", {3'b000, flush}, {3'b000, e.flush});
            chk("redirect_valid", {3'b000, redirect_valid}, {3'b000, e.rv});
            chk("redirect_sel", {3'b000, redirect_sel}, {3'b000, e.rsel});
            chk("div_start", {3'b000, div_start}, {3'b000, e.dstart});
            chk("div_busy", {3'b000, div_busy}, {3'b000, e.dbusy});
            chk("fwd_rs_sel", {2'b00, fwd_rs_sel}, {2'b00, e.frs});
            chk("fwd_rt_sel", {2'b00, fwd_rt_sel}, {2'b00, e.frt});
         end
      end
   end

   initial begin
      clear_in();
      reset = 1'b1;
      @(posedge clk); #1;
      model_update();
      step();                    // reset held, all valids low
      reset = 1'b0;
      step();

      // load-use then MEM forward
      ex_valid = 1'b1; ex_load_op = 1'b1; ex_reg_we = 1'b1; ex_dest = 5'd5;
      id_valid = 1'b1; id_rs = 5'd5; id_rs_use = 1'b1;
      step();
      clear_in();
      id_valid = 1'b1; id_rs = 5'd5; id_rs_use = 1'b1;
      mem_valid = 1'b1; mem_reg_we = 1'b1; mem_dest = 5'd5;
      step();

      // forward priority on r7, then EX writing r0
      clear_in();
      id_valid = 1'b1; id_rt = 5'd7; id_rt_use = 1'b1;
      ex_valid = 1'b1; ex_reg_we = 1'b1; ex_dest = 5'd7;
      mem_valid = 1'b1; mem_reg_we = 1'b1; mem_dest = 5'd7;
      wb_valid = 1'b1; wb_reg_we = 1'b1; wb_dest = 5'd7;
      step();
      ex_dest = 5'd0;
      step();

      // clean divide, then a divide whose last cycle sees MEM stalled
      clear_in();
      set_div(DC);
      clear_in(); step();
      set_div(DC - 1);
      mem_valid = 1'b1; mem_ready = 1'b0;
      step(); step(); step();
      mem_ready = 1'b1;
      step();
      clear_in(); step();

      // exception mid-divide, then eret, then both together
      set_div(2);
      wb_valid = 1'b1; wb_exc = 1'b1;
      step();
      clear_in(); step(); step();
      wb_valid = 1'b1; wb_eret = 1'b1; step();
      clear_in(); step(); step();
      wb_valid = 1'b1; wb_eret = 1'b1; wb_exc = 1'b1; step();
      clear_in(); step(); step();

      // reset mid-divide and with a redirect pending
      set_div(2);
      wb_valid = 1'b1; wb_eret = 1'b1; step();
      clear_in(); set_div(1);
      reset = 1'b1; step();
      clear_in(); step();

      for (int i = 0; i < 1500; i++) begin
         gen_random();
         step();
      end
      clear_in(); step();

      for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain: %0d entries left, required 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
